// File: rtl/store_unit.sv
// Store path between EX/MEM and data memory: lane placement, byte strobes and a valid/ready write beat.
// Build option STORE_MISALIGN_SPLIT_EN: word-crossing stores become two beats instead of a fault.
//
// state | meaning
// IDLE  | ready for a store request
// BEAT0 | first (or only) write beat at the base word
// BEAT1 | second beat at base+4 (split build only)
// FAULT | one-cycle fault pulse, no memory beat
module store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        fault
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
`ifdef STORE_MISALIGN_SPLIT_EN
    localparam logic [1:0] BEAT1 = 2'd2;
`endif
    localparam logic [1:0] FAULT = 2'd3;

    logic [1:0]  state;
    logic [1:0]  k;
    logic [3:0]  size_m;
    logic        legal;
    logic        bad;
    logic [7:0]  strb_wide;
    logic [31:0] beat0_data;

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    // Strobes are built on an 8-lane window: the upper nibble is whatever spills into the next word.
    always_comb begin
        k      = addr[1:0];
        legal  = 1'b1;
        size_m = 4'b0000;
        case (funct3)
            3'b000:  size_m = 4'b0001;
            3'b001:  size_m = 4'b0011;
            3'b010:  size_m = 4'b1111;
            default: legal  = 1'b0;
        endcase
        strb_wide = {4'b0000, size_m} << k;
    end

`ifdef STORE_MISALIGN_SPLIT_EN
    logic [63:0] data_wide;
    logic [31:0] beat1_data;
    logic [31:0] b1_wdata;
    logic [3:0]  b1_wstrb;

    always_comb begin
        data_wide  = {32'b0, wdata} << {k, 3'b000};
        beat0_data = data_wide[31:0] & lane_mask(strb_wide[3:0]);
        beat1_data = data_wide[63:32] & lane_mask(strb_wide[7:4]);
        bad        = !legal;
    end
`else
    always_comb begin
        beat0_data = (wdata << {k, 3'b000}) & lane_mask(strb_wide[3:0]);
        // Without splitting, word-crossing stores and odd-aligned halves are rejected.
        bad        = !legal || (|strb_wide[7:4]) || ((funct3 == 3'b001) && k[0]);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= 32'b0;
            mem_wdata <= 32'b0;
            mem_wstrb <= 4'b0;
            fault     <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            b1_wdata  <= 32'b0;
            b1_wstrb  <= 4'b0;
`endif
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (bad) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= beat0_data;
                            mem_wstrb <= strb_wide[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
                            b1_wdata  <= beat1_data;
                            b1_wstrb  <= strb_wide[7:4];
`endif
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                        if (|b1_wstrb) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_wdata <= b1_wdata;
                            mem_wstrb <= b1_wstrb;
                        end else begin
                            state     <= IDLE;
                            mem_valid <= 1'b0;
                        end
`else
                        state     <= IDLE;
                        mem_valid <= 1'b0;
`endif
                    end
                end
`ifdef STORE_MISALIGN_SPLIT_EN
                BEAT1: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                    end
                end
`endif
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: directed stores push expected beats/faults, a negedge monitor checks them.
// Expectations follow STORE_MISALIGN_SPLIT_EN the same way the design build does.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;
    logic        fault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_fault;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .busy      (busy),
        .fault     (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.is_fault = 1'b0; e.a = a; e.d = d; e.s = s;
        q.push_back(e);
    endtask

    task automatic push_fault();
        exp_t e;
        e.is_fault = 1'b1; e.a = 32'b0; e.d = 32'b0; e.s = 4'b0;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (mem_valid && mem_ready) begin
                check("beat_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("beat_kind", 0, 32'(e.is_fault));
                    check("beat_addr", mem_addr, e.a);
                    check("beat_data", mem_wdata, e.d);
                    check("beat_strb", 32'(mem_wstrb), 32'(e.s));
                end
            end
            if (fault) begin
                check("fault_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("fault_kind", 1, 32'(e.is_fault));
                    check("fault_no_beat", 32'(mem_valid), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("issue_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        funct3    = f;
        addr      = a;
        wdata     = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic fault_case(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        push_fault();
        issue(f, a, d);
        check("fault_n1", 32'(fault), 1);
        check("fault_n1_valid", 32'(mem_valid), 0);
        tick();
        check("fault_n2_clear", 32'(fault), 0);
        check("fault_n2_ready", 32'(req_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; funct3 = 3'b0; addr = 32'b0; wdata = 32'b0; mem_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(mem_valid), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", 32'(mem_wstrb), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready_low", 32'(req_ready), 0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", 32'(req_ready), 1);

        // sb, high lane, memory always ready: 2-cycle occupancy
        mem_ready = 1'b1;
        push_beat(32'h0000_1000, 32'hDD00_0000, 4'b1000);
        issue(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        check("sb_valid_n1", 32'(mem_valid), 1);
        check("sb_busy_n1", 32'(busy), 1);
        tick();
        check("sb_valid_n2", 32'(mem_valid), 0);
        check("sb_ready_n2", 32'(req_ready), 1);

        // sh held off by memory for 3 cycles
        mem_ready = 1'b0;
        push_beat(32'h0000_2000, 32'h5678_0000, 4'b1100);
        issue(3'b001, 32'h0000_2002, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            check("sh_hold_valid", 32'(mem_valid), 1);
            check("sh_hold_addr", mem_addr, 32'h0000_2000);
            check("sh_hold_data", mem_wdata, 32'h5678_0000);
            check("sh_hold_strb", 32'(mem_wstrb), 32'hC);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("sh_done_valid", 32'(mem_valid), 0);
        check("sh_done_ready", 32'(req_ready), 1);

`ifdef STORE_MISALIGN_SPLIT_EN
        push_beat(32'h0000_3000, 32'h2233_4400, 4'b1110);
        push_beat(32'h0000_3004, 32'h0000_0011, 4'b0001);
        issue(3'b010, 32'h0000_3001, 32'h1122_3344);
        check("sw_split_b0_valid", 32'(mem_valid), 1);
        check("sw_split_b0_addr", mem_addr, 32'h0000_3000);
        tick();
        check("sw_split_b1_nobubble", 32'(mem_valid), 1);
        check("sw_split_b1_addr", mem_addr, 32'h0000_3004);
        tick();
        check("sw_split_done_valid", 32'(mem_valid), 0);
        check("sw_split_done_ready", 32'(req_ready), 1);

        push_beat(32'hFFFF_FFFC, 32'hBABE_0000, 4'b1100);
        push_beat(32'h0000_0000, 32'h0000_CAFE, 4'b0011);
        issue(3'b010, 32'hFFFF_FFFE, 32'hCAFE_BABE);
        wait_idle();

        push_beat(32'h0000_4000, 32'h00BE_EF00, 4'b0110);
        issue(3'b001, 32'h0000_4001, 32'h0000_BEEF);
        wait_idle();

        push_beat(32'h0000_4000, 32'hB200_0000, 4'b1000);
        push_beat(32'h0000_4004, 32'h0000_00A1, 4'b0001);
        issue(3'b001, 32'h0000_4003, 32'h0000_A1B2);
        wait_idle();
`else
        fault_case(3'b010, 32'h0000_3001, 32'h1122_3344);
        fault_case(3'b010, 32'hFFFF_FFFE, 32'hCAFE_BABE);
        fault_case(3'b001, 32'h0000_4001, 32'h0000_BEEF);
        fault_case(3'b001, 32'h0000_4003, 32'h0000_A1B2);
`endif

        push_beat(32'h0000_5000, 32'hDEAD_BEEF, 4'b1111);
        issue(3'b010, 32'h0000_5000, 32'hDEAD_BEEF);
        wait_idle();
        push_beat(32'h0000_6000, 32'h0000_5A00, 4'b0010);
        issue(3'b000, 32'h0000_6001, 32'hFFFF_FF5A);
        wait_idle();
        push_beat(32'h0000_6000, 32'h0000_1234, 4'b0011);
        issue(3'b001, 32'h0000_6000, 32'hFFFF_1234);
        wait_idle();

        fault_case(3'b011, 32'h0000_8000, 32'h0102_0304);
        fault_case(3'b100, 32'h0000_8000, 32'h0102_0304);
        fault_case(3'b111, 32'h0000_8001, 32'h0102_0304);

        // reset while BEAT0 is stalled: transaction abandoned, no second beat
        mem_ready = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        issue(3'b010, 32'h0000_7001, 32'h5555_AAAA);
`else
        issue(3'b010, 32'h0000_7000, 32'h5555_AAAA);
`endif
        check("mid_valid_before", 32'(mem_valid), 1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(mem_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_data", mem_wdata, 0);
        check("mid_rst_strb", 32'(mem_wstrb), 0);
        mem_ready = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        check("mid_no_beat1", 32'(mem_valid), 0);
        check("mid_ready", 32'(req_ready), 1);

        tick();
        check("sb_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
